// File: rtl/lsu_align_unit_if.sv
// lsu_align_unit_if: data-memory beat port between the LSU alignment unit and memory
// Signals:
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata   unit -> memory (one beat, held until mem_gnt)
//   mem_gnt, mem_rvalid, mem_rdata                 memory -> unit
// Modports: master (alignment unit), slave (memory)
interface lsu_align_unit_if #(
    parameter int XLEN = 32
);
    localparam int NB = XLEN / 8;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [NB-1:0]   mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_align_unit.sv
// lsu_align_unit: MEM-stage load/store alignment between the pipeline request and the data-memory port
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_write, req_fun3, req_addr, req_wdata latched on accept
//   rsp_valid             one-cycle completion pulse with rsp_rdata (extended load data) and rsp_err
//   stall_MEM             holds the pipeline while an access is in flight
//   mem                   master side of the data-memory beat port
module lsu_align_unit #(
    parameter int XLEN               = 32,
    parameter bit SUPPORT_MISALIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       req_fun3,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [XLEN-1:0]  req_wdata,
    output logic             rsp_valid,
    output logic [XLEN-1:0]  rsp_rdata,
    output logic             rsp_err,
    output logic             stall_MEM,
    lsu_align_unit_if.master mem
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam logic [2:0] IDLE = 3'd0, REQ1 = 3'd1, WAIT1 = 3'd2, REQ2 = 3'd3, WAIT2 = 3'd4, RESP = 3'd5;

    logic [2:0]        state_q, state_d;
    logic              write_q, write_d;
    logic [2:0]        fun3_q, fun3_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              cross_q, cross_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   beat0_q, beat0_d;
    logic [XLEN-1:0]   beat1_q, beat1_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [NB-1:0]     mem_be_q, mem_be_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

    logic              accept, fire, in_cross, in_illegal, reject;
    logic [4:0]        in_end;
    logic [OW-1:0]     off;
    logic [NB-1:0]     size_mask;
    logic [2*NB-1:0]   be_wide;
    logic [2*XLEN-1:0] wd_wide;
    logic [XLEN-1:0]   line_addr, raw, lo_mask, top_bit, ext;

    assign accept     = req_valid && state_q == IDLE;
    assign fire       = mem_req_q && mem.mem_gnt;
    assign in_end     = 5'(req_addr[OW-1:0]) + (5'd1 << req_fun3[1:0]);
    assign in_cross   = in_end > 5'(NB);
    assign in_illegal = (req_fun3[1:0] == 2'd3 && XLEN == 32) || (req_write && req_fun3[2]) || req_fun3 == 3'b111;
    assign reject     = in_illegal || (in_cross && !SUPPORT_MISALIGNED);

    // Both beats come from one double-width shift: the low half is beat 1, the high half is what spilled into beat 2.
    assign off       = addr_q[OW-1:0];
    assign size_mask = NB'((16'd1 << (5'd1 << fun3_q[1:0])) - 16'd1);
    assign be_wide   = {{NB{1'b0}}, size_mask} << off;
    assign wd_wide   = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
    assign line_addr = {addr_q[XLEN-1:OW], {OW{1'b0}}};

    // Load data: splice the beats, keep the access width, then fill the upper bits from the access's top bit.
    assign raw     = XLEN'({cross_q ? beat1_q : {XLEN{1'b0}}, beat0_q} >> {off, 3'b000});
    assign lo_mask = (XLEN'(1) << (7'd8 << fun3_q[1:0])) - XLEN'(1);
    assign top_bit = lo_mask & ~(lo_mask >> 1);
    assign ext     = (raw & lo_mask) | ((!fun3_q[2] && |(raw & top_bit)) ? ~lo_mask : '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = reject ? RESP : REQ1;
            REQ1:    if (fire) state_d = !write_q ? WAIT1 : (cross_q ? REQ2 : RESP);
            WAIT1:   if (mem.mem_rvalid) state_d = cross_q ? REQ2 : RESP;
            REQ2:    if (fire) state_d = write_q ? RESP : WAIT2;
            WAIT2:   if (mem.mem_rvalid) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // mem_* are registered: a beat is raised the cycle after entering REQ1/REQ2 and dropped the cycle after gnt.
    always_comb begin
        write_d     = accept ? req_write : write_q;
        fun3_d      = accept ? req_fun3 : fun3_q;
        addr_d      = accept ? req_addr : addr_q;
        wdata_d     = accept ? req_wdata : wdata_q;
        cross_d     = accept ? in_cross : cross_q;
        err_d       = accept ? reject : err_q;
        beat0_d     = (state_q == WAIT1 && mem.mem_rvalid) ? mem.mem_rdata : beat0_q;
        beat1_d     = (state_q == WAIT2 && mem.mem_rvalid) ? mem.mem_rdata : beat1_q;
        mem_req_d   = (state_q == REQ1 || state_q == REQ2) && !fire;
        mem_we_d    = mem_req_d && write_q;
        mem_addr_d  = !mem_req_d ? '0 : (state_q == REQ2) ? line_addr + XLEN'(NB) : line_addr;
        mem_be_d    = !mem_req_d ? '0 : (state_q == REQ2) ? be_wide[2*NB-1:NB] : be_wide[NB-1:0];
        mem_wdata_d = !mem_req_d ? '0 : (state_q == REQ2) ? wd_wide[2*XLEN-1:XLEN] : wd_wide[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            fun3_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cross_q     <= 1'b0;
            err_q       <= 1'b0;
            beat0_q     <= '0;
            beat1_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            fun3_q      <= fun3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cross_q     <= cross_d;
            err_q       <= err_d;
            beat0_q     <= beat0_d;
            beat1_q     <= beat1_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready     = state_q == IDLE;
    assign rsp_valid     = state_q == RESP;
    assign rsp_err       = rsp_valid && err_q;
    assign rsp_rdata     = (rsp_valid && !write_q && !err_q) ? ext : '0;
    assign stall_MEM     = !req_ready && !rsp_valid;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;
endmodule
